// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared constants, types and state encoding for the CNN
//                pipeline stages (conv2 window scheduling).
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  localparam int CONV2_IMG_W  = 13;
  localparam int CONV2_IMG_H  = 13;
  localparam int CONV2_IN_CH  = 8;
  localparam int CONV2_OUT_CH = 16;
  localparam int CONV_K       = 3;

  // One 3x3 window across all input channels
  localparam int WIN_BITS = CONV_K * CONV_K * CONV2_IN_CH;

  // Row/column counter width (covers 0..12)
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } conv2_state_e;

endpackage
`default_nettype wire

// File: rtl/conv2_window_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv2_window_sched_if
//  Description : Pixel input stream and 3x3x8 window output stream of the
//                conv2 window scheduler, both valid/ready handshaked.
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv2_window_sched_if #(
  parameter int NUM_CH = cnn_pkg::CONV2_IN_CH,
  parameter int WIN_W  = cnn_pkg::WIN_BITS
);

  logic [NUM_CH-1:0]          pix_in;
  logic                       pix_valid;
  logic                       pix_ready;
  logic [WIN_W-1:0]           win_data;
  logic                       win_valid;
  logic                       win_ready;
  logic [cnn_pkg::CNT_W-1:0]  win_row;
  logic [cnn_pkg::CNT_W-1:0]  win_col;

  // Scheduler side: consumes pixels, produces windows
  modport slave (
    input  pix_in, pix_valid, win_ready,
    output pix_ready, win_data, win_valid, win_row, win_col
  );

  // Environment side: produces pixels, consumes windows
  modport master (
    output pix_in, pix_valid, win_ready,
    input  pix_ready, win_data, win_valid, win_row, win_col
  );

endinterface
`default_nettype wire

// File: rtl/conv2_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : conv2_line_buf
//  Description : Two row buffers plus a 3x3 shift window. Each shift pushes
//                the column {row-2, row-1, current} in from the right.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2_line_buf
  import cnn_pkg::*;
#(
  parameter int IMG_W  = CONV2_IMG_W,
  parameter int NUM_CH = CONV2_IN_CH
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  shift_en,
  input  wire logic [CNT_W-1:0]      col,
  input  wire logic [NUM_CH-1:0]     pix_in,
  output logic      [9*NUM_CH-1:0]   window
);

  // lb0_q holds the previous row, lb1_q the row above that
  logic [NUM_CH-1:0] lb0_q [IMG_W];
  logic [NUM_CH-1:0] lb1_q [IMG_W];
  // win_q[r][k]: r=0 top row, k=0 left column
  logic [NUM_CH-1:0] win_q [3][3];

  // Row buffers and window advance together on every accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          win_q[r][k] <= '0;
        end
      end
    end else if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_q[col];
      win_q[1][2] <= lb0_q[col];
      win_q[2][2] <= pix_in;
      lb1_q[col]  <= lb0_q[col];
      lb0_q[col]  <= pix_in;
    end
  end

  // Pack as channel-major: channel c in bits [9c+8:9c], bit r*3+k inside
  always_comb begin
    window = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          window[c*9 + r*3 + k] = win_q[r][k][c];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv2_window_sched.sv
`default_nettype none
// ============================================================================
//  Module      : conv2_window_sched
//  Description : Conv2 window scheduler. Accepts a raster pixel stream,
//                builds 3x3x8 windows and hands them to the conv2 compute
//                stage tagged with output coordinates; tracks frame state.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2_window_sched
  import cnn_pkg::*;
#(
  parameter int IMG_W  = CONV2_IMG_W,
  parameter int IMG_H  = CONV2_IMG_H,
  parameter int NUM_CH = CONV2_IN_CH,
  parameter int K      = CONV_K
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               start,
  output logic                    busy,
  output logic                    frame_done,
  conv2_window_sched_if.slave     bus
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] KM1      = CNT_W'(K - 1);

  conv2_state_e      state_q, state_d;
  logic [CNT_W-1:0]  row_q, col_q;
  logic [CNT_W-1:0]  win_row_q, win_col_q;
  logic              win_valid_q;

  logic accept, win_hs, last_pix, complete;

  // Pixels stall only while a presented window is being held back
  assign bus.pix_ready = (state_q == S_STREAM) && !(win_valid_q && !bus.win_ready);
  assign accept        = bus.pix_valid && bus.pix_ready;
  assign win_hs        = win_valid_q && bus.win_ready;
  assign last_pix      = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign complete      = accept && (row_q >= KM1) && (col_q >= KM1);

  assign busy          = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign frame_done    = (state_q == S_DONE);
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;

  // Window storage; its contents only move on accept, which cannot happen
  // while a window is stalled, so win_data stays stable until handshake
  conv2_line_buf #(
    .IMG_W  (IMG_W),
    .NUM_CH (NUM_CH)
  ) u_line_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .col      (col_q),
    .pix_in   (bus.pix_in),
    .window   (bus.win_data)
  );

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Frame sequencing: stream until the last pixel, then wait for last window
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start)               state_d = S_STREAM;
      S_STREAM: if (accept && last_pix)  state_d = S_DRAIN;
      S_DRAIN:  if (win_hs)              state_d = S_DONE;
      S_DONE:                            state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // Raster position of the next pixel to accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      row_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Window valid and output coordinate; a new completion overrides a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else if (complete) begin
      win_valid_q <= 1'b1;
      win_row_q   <= row_q - KM1;
      win_col_q   <= col_q - KM1;
    end else if (win_hs) begin
      win_valid_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv2_window_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv2_window_sched
//  Description : Self-checking bench for conv2_window_sched. Expected windows
//                are extracted directly from a stored frame image.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2_window_sched;
  import cnn_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic frame_done;

  conv2_window_sched_if bus ();

  conv2_window_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] d;
    logic [3:0]  r;
    logic [3:0]  c;
  } win_t;

  int   total  = 0;
  int   passed = 0;
  win_t exp_q[$];
  win_t e;
  logic [7:0] img [13][13];
  bit   rand_rdy = 1'b0;
  int   cyc = 0, last_hs_cyc = -10, done_cnt = 0, hs_cnt = 0, nz_cnt = 0;
  bit   stalled_prev = 1'b0;
  logic [71:0] stall_d;
  logic [3:0]  stall_r, stall_c;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Golden window: bit ch*9 + r*3 + k = channel ch of pixel (r0+r, c0+k)
  function automatic logic [71:0] golden(input int r0, input int c0);
    logic [71:0] w = '0;
    for (int ch = 0; ch < 8; ch++)
      for (int rr = 0; rr < 3; rr++)
        for (int kk = 0; kk < 3; kk++)
          w[ch*9 + rr*3 + kk] = img[r0+rr][c0+kk][ch];
    return w;
  endfunction

  // mode 0: all ones, 1: single ch0 pixel at (6,6), 2: ramp, 3: random
  task automatic set_img(input int mode);
    for (int r = 0; r < 13; r++)
      for (int c = 0; c < 13; c++)
        case (mode)
          0:       img[r][c] = 8'hFF;
          1:       img[r][c] = (r == 6 && c == 6) ? 8'h01 : 8'h00;
          2:       img[r][c] = 8'((r*13 + c) % 256);
          default: img[r][c] = 8'($urandom);
        endcase
    exp_q.delete();
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++)
        exp_q.push_back('{d: golden(r, c), r: 4'(r), c: 4'(c)});
    hs_cnt = 0; nz_cnt = 0; done_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_pix_ready"},  72'(bus.pix_ready), 72'd0);
    chk({pfx, "_win_valid"},  72'(bus.win_valid), 72'd0);
    chk({pfx, "_win_data"},   bus.win_data,       72'd0);
    chk({pfx, "_win_row"},    72'(bus.win_row),   72'd0);
    chk({pfx, "_win_col"},    72'(bus.win_col),   72'd0);
    chk({pfx, "_busy"},       72'(busy),          72'd0);
    chk({pfx, "_frame_done"}, 72'(frame_done),    72'd0);
  endtask

  // Drives one frame; optionally pulses start mid-frame or aborts by reset
  task automatic feed_frame(input int abort_at, input bit mid_start, input bit gaps);
    bit acc;
    int budget;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int p = 0; p < 169; p++) begin
      bus.pix_in    = img[p/13][p%13];
      bus.pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mid_start && p == 50) start = 1'b1;
      acc = 1'b0; budget = 0;
      while (!acc && budget < 500) begin
        @(negedge clk);
        acc = bus.pix_valid && bus.pix_ready;
        @(posedge clk); #1;
        start = 1'b0;
        budget++;
        bus.pix_valid = 1'b1;
      end
      if (!acc) begin
        chk("pixel_accept_timeout", 72'd0, 72'd1);
        bus.pix_valid = 1'b0;
        return;
      end
      if (p + 1 == abort_at) begin
        bus.pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_frame_done", 72'(done_cnt), 72'd0);
        chk("abort_idle", 72'(busy), 72'd0);
        return;
      end
    end
    bus.pix_valid = 1'b0;
    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("frame_done_seen", 72'(done_cnt), 72'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("frame_done_once", 72'(done_cnt), 72'd1);
    chk("window_count",    72'(hs_cnt),   72'd121);
    chk("busy_after",      72'(busy),     72'd0);
  endtask

  // Consumer ready: always 1 or a coin flip per cycle
  initial begin
    bus.win_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.win_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Window consumer / checker, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev) begin
          chk("stall_valid", 72'(bus.win_valid), 72'd1);
          chk("stall_data",  bus.win_data,       stall_d);
          chk("stall_row",   72'(bus.win_row),   72'(stall_r));
          chk("stall_col",   72'(bus.win_col),   72'(stall_c));
        end
        if (bus.win_valid && !bus.win_ready) begin
          chk("stall_pix_ready", 72'(bus.pix_ready), 72'd0);
          stalled_prev = 1'b1;
          stall_d = bus.win_data; stall_r = bus.win_row; stall_c = bus.win_col;
        end else begin
          stalled_prev = 1'b0;
        end
        if (bus.win_valid && bus.win_ready) begin
          hs_cnt++;
          last_hs_cyc = cyc;
          if (bus.win_data != 72'd0) nz_cnt++;
          if (exp_q.size() == 0) begin
            chk("extra_window", 72'd1, 72'd0);
          end else begin
            e = exp_q.pop_front();
            chk("win_data", bus.win_data,     e.d);
            chk("win_row",  72'(bus.win_row), 72'(e.r));
            chk("win_col",  72'(bus.win_col), 72'(e.c));
          end
        end
        if (frame_done) begin
          done_cnt++;
          chk("done_timing",    72'(last_hs_cyc),  72'(cyc - 1));
          chk("done_all_wins",  72'(exp_q.size()), 72'd0);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // pixels offered before start are not consumed
    bus.pix_valid = 1'b1;
    bus.pix_in    = 8'hA5;
    repeat (5) begin
      @(negedge clk);
      chk("idle_pix_ready", 72'(bus.pix_ready), 72'd0);
      chk("idle_busy",      72'(busy),          72'd0);
    end
    @(posedge clk); #1 bus.pix_valid = 1'b0;

    // all-ones frame, consumer always ready
    rand_rdy = 1'b0;
    set_img(0);
    feed_frame(0, 1'b0, 1'b0);

    // single set pixel: exactly the 9 windows around it are nonzero
    set_img(1);
    feed_frame(0, 1'b0, 1'b0);
    chk("single_pixel_nonzero", 72'(nz_cnt), 72'd9);

    // ramp with a stalling consumer
    rand_rdy = 1'b1;
    set_img(2);
    feed_frame(0, 1'b0, 1'b0);

    // random data, input gaps, start pulsed mid-frame
    set_img(3);
    feed_frame(0, 1'b1, 1'b1);

    // reset after 80 pixels, then a fresh full frame
    set_img(3);
    feed_frame(80, 1'b0, 1'b0);
    set_img(3);
    feed_frame(0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv2_window_sched.md
Name: conv2_window_sched

Overview:
Sequences the second convolution stage. Accepts the binarized 13x13x8 feature map from the pool1 stage as a raster stream of one pixel per cycle, with all 8 channels in parallel. Keeps two line buffers plus a 3x3 shift window and issues each valid 3x3x8 window to conv2_calc_2 over a valid/ready handshake, tagged with its output coordinate. Owns frame start, busy and done signalling for conv2.

Parameters:
IMG_W, 13, input feature-map width
IMG_H, 13, input feature-map height
NUM_CH, 8, input channels (bits per pixel)
K, 3, kernel size (fixed 3; other values unsupported)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms a new frame when idle
pix_in  in  NUM_CH  pixel, bit c = channel c
pix_valid  in  1  pix_in valid
pix_ready  out  1  block accepts pixel this cycle
win_data  out  K*K*NUM_CH (72)  window to conv2_calc_2 pixel_windows
win_valid  out  1  win_data valid; drives conv2_calc_2 valid_in_buf
win_ready  in  1  consumer accepts window
win_row  out  4  output row of window, 0..IMG_H-K (0..10)
win_col  out  4  output col of window, 0..IMG_W-K (0..10)
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last window handshake

Behaviour:
- Clock is clk; reset is asynchronous, active-low, named rst_n. On reset, all outputs are 0, counters are 0, state is IDLE, and line buffers and window registers are cleared.
- States:
  - IDLE: pix_ready=0. A start pulse moves to STREAM and clears row/col.
  - STREAM: pix_ready = !(win_valid && !win_ready).
  - DRAIN: entered after the final pixel (row IMG_H-1, col IMG_W-1) is accepted; waits for the last window handshake.
  - DONE: one cycle, frame_done=1, then IDLE.
- busy=1 in STREAM and DRAIN.
- A pixel is accepted when pix_valid && pix_ready.
- Counters col 0..IMG_W-1 and row 0..IMG_H-1 advance only on accept. col wraps to 0 and increments row.
- On accept:
  - The window shifts left by one column.
  - The new right column is {linebuf1[col], linebuf0[col], pix_in} (top to bottom).
  - linebuf1[col]<=linebuf0[col]; linebuf0[col]<=pix_in.
- A window is complete when the accepted pixel has row>=K-1 and col>=K-1.
  - The next cycle sets win_valid=1 with win_row=row-2 and win_col=col-2, registered.
  - Latency is 1 cycle from the completing accept to win_valid.
- win_valid stays high with win_data/win_row/win_col stable until win_ready. It clears on handshake unless a new window completes in the same cycle, in which case it stays 1 with the new data.
- Window bit layout: channel c occupies bits [9c+8:9c]. Within a channel, bit r*3+k holds window row r (0=top), col k (0=left).
- Exactly (IMG_H-2)*(IMG_W-2)=121 windows per frame, in raster order.
- Pixels at col 0..1 and row 0..1 produce no window. The shift still occurs.
- start while busy is ignored. pix_valid in IDLE is ignored (pix_ready=0).
- Final pixel accepted: go to DRAIN. When the last window handshakes, go to DONE. If the handshake happens in the same cycle that DRAIN is entered, go to DONE directly.
- Reset mid-frame aborts immediately. Partial-frame state is discarded and no frame_done is issued.

Decomposition:
- Shared package cnn_pkg holds:
  - constants CONV2_IMG_W=13, CONV2_IMG_H=13, CONV2_IN_CH=8, CONV2_OUT_CH=16, CONV_K=3;
  - WIN_BITS = K*K*IN_CH;
  - state encoding enum IDLE/STREAM/DRAIN/DONE.
- One natural sub-module: conv2_line_buf. It holds the two IMG_W x NUM_CH row buffers and the 3x3 shift window, with inputs shift_en, col and pix_in, and output window.
- The FSM, counters and handshake stay in the top module.

Test Plan:
- All-ones frame, win_ready=1 → 121 windows, each win_data=72'hFF_FFFF_FFFF_FFFF_FFFF; win_row/col run 0,0 to 10,10 in raster order; frame_done exactly once, 1 cycle after the last handshake.
- All-zero frame except ch0 pixel (6,6)=1 → exactly 9 windows nonzero, at win_row/col 4..6 each. For window (4,4), only bit 8 (r=2,k=2) is set; for window (6,6), only bit 0 is set.
- Ramp pattern pix_in = (row*13+col) mod 256 → every window matches the golden 3x3x8 extraction under the bit layout above.
- Random win_ready (50%) with pix_valid held high → win_data is held stable while stalled; pix_ready=0 while stalled; no window is lost or duplicated; count is 121.
- start pulsed mid-frame → ignored and counters unaffected; pix_valid before start → pix_ready=0 and nothing is consumed.
- rst_n asserted after 80 pixels → outputs are 0 immediately; no frame_done. A fresh start then runs a full frame correctly (121 windows).
